// File: rtl/fifo_drain_acc_pkg.sv
// Shared types for the FIFO drain accumulator: FSM state encoding and the
// pop counter width helper.
package fifo_drain_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Width needed to count 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_drain_accumulator_lane_sum.sv
// Combinational sum of PAR_READ signed lanes, each sign-extended to ACC_WIDTH;
// additions wrap modulo 2^ACC_WIDTH.
module lane_sum #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PAR_READ   = 1,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic [DATA_WIDTH*PAR_READ-1:0] i_data,
  output logic [ACC_WIDTH-1:0]           o_sum
);

  logic signed [DATA_WIDTH-1:0] w_lane;
  logic        [ACC_WIDTH-1:0]  w_acc;

  always_comb begin
    w_lane = '0;
    w_acc  = '0;
    for (int unsigned i = 0; i < PAR_READ; i++) begin
      w_lane = i_data[i*DATA_WIDTH +: DATA_WIDTH];
      w_acc  = w_acc + ACC_WIDTH'(w_lane);
    end
  end

  assign o_sum = w_acc;

endmodule

// File: rtl/fifo_drain_accumulator.sv
// Pops SUM_LEN word groups from a parallel-read FIFO, accumulates them signed,
// and offers the total on a valid/ready port. Optional: FIFO_DRAIN_ACC_SATURATE_EN.
module fifo_drain_accumulator
  import fifo_drain_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PAR_READ   = 1,
  parameter int unsigned SUM_LEN    = 9,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           fifo_valid,
  input  logic [DATA_WIDTH*PAR_READ-1:0] fifo_data,
  output logic                           fifo_r_en,
  output logic [ACC_WIDTH-1:0]           sum_out,
  output logic                           sum_valid,
  input  logic                           sum_ready,
  output logic                           busy,
`ifdef FIFO_DRAIN_ACC_SATURATE_EN
  output logic                           sat_flag,
`endif
  output logic [cnt_width(SUM_LEN)-1:0]  pop_cnt
);

  localparam int unsigned CW = cnt_width(SUM_LEN);

  state_t                r_state;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_sum_out;
  logic                  r_sum_valid;
  logic [CW-1:0]         r_pop_cnt;
  logic [ACC_WIDTH-1:0]  w_lane_sum;
  logic [ACC_WIDTH-1:0]  w_acc_next;
  logic                  w_pop;

  lane_sum #(
    .DATA_WIDTH (DATA_WIDTH),
    .PAR_READ   (PAR_READ),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_lane_sum (
    .i_data (fifo_data),
    .o_sum  (w_lane_sum)
  );

  assign w_pop = (r_state == ACCUM) && fifo_valid;

`ifdef FIFO_DRAIN_ACC_SATURATE_EN
  logic                 r_sat;
  logic [ACC_WIDTH:0]   w_wide;
  logic                 w_clamp;

  // One guard bit: overflow when the guard and sign bits disagree; the guard
  // bit carries the true sign and selects which rail to clamp to.
  assign w_wide     = {r_acc[ACC_WIDTH-1], r_acc} + {w_lane_sum[ACC_WIDTH-1], w_lane_sum};
  assign w_clamp    = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];
  assign w_acc_next = w_clamp ? {w_wide[ACC_WIDTH], {(ACC_WIDTH-1){~w_wide[ACC_WIDTH]}}}
                              : w_wide[ACC_WIDTH-1:0];
  assign sat_flag   = r_sat;
`else
  assign w_acc_next = r_acc + w_lane_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_pop_cnt   <= '0;
      r_sum_out   <= '0;
      r_sum_valid <= 1'b0;
`ifdef FIFO_DRAIN_ACC_SATURATE_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc     <= '0;
            r_pop_cnt <= '0;
`ifdef FIFO_DRAIN_ACC_SATURATE_EN
            r_sat     <= 1'b0;
`endif
            r_state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_pop) begin
            r_acc <= w_acc_next;
`ifdef FIFO_DRAIN_ACC_SATURATE_EN
            r_sat <= r_sat | w_clamp;
`endif
            if (r_pop_cnt == CW'(SUM_LEN - 1)) begin
              r_sum_out   <= w_acc_next;
              r_sum_valid <= 1'b1;
              r_pop_cnt   <= CW'(SUM_LEN);
              r_state     <= HOLD;
            end else begin
              r_pop_cnt <= r_pop_cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (r_sum_valid && sum_ready) begin
            r_sum_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fifo_r_en = w_pop;
  assign sum_out   = r_sum_out;
  assign sum_valid = r_sum_valid;
  assign pop_cnt   = r_pop_cnt;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_drain_accumulator.sv
// Randomized self-checking bench: a wide instance (PAR_READ=2, SUM_LEN=3) and a
// narrow 16-bit accumulator instance exercising wrap/saturation at the rails.
module tb_fifo_drain_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Main instance: 2 lanes of 16 bits, 3 pops, 40-bit accumulator.
  logic        m_start = 1'b0, m_valid = 1'b0, m_ready = 1'b0;
  logic [31:0] m_data = '0;
  logic        m_r_en, m_sum_valid, m_busy;
  logic [39:0] m_sum_out;
  logic [1:0]  m_pop_cnt;
`ifdef FIFO_DRAIN_ACC_SATURATE_EN
  logic        m_sat;
`endif

  fifo_drain_accumulator #(
    .DATA_WIDTH (16),
    .PAR_READ   (2),
    .SUM_LEN    (3),
    .ACC_WIDTH  (40)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (m_start),
    .fifo_valid (m_valid),
    .fifo_data  (m_data),
    .fifo_r_en  (m_r_en),
    .sum_out    (m_sum_out),
    .sum_valid  (m_sum_valid),
    .sum_ready  (m_ready),
    .busy       (m_busy),
`ifdef FIFO_DRAIN_ACC_SATURATE_EN
    .sat_flag   (m_sat),
`endif
    .pop_cnt    (m_pop_cnt)
  );

  // Narrow instance: 16-bit words into a 16-bit accumulator, 2 pops.
  logic        o_start = 1'b0, o_valid = 1'b0, o_ready = 1'b0;
  logic [15:0] o_data = '0;
  logic        o_r_en, o_sum_valid, o_busy;
  logic [15:0] o_sum_out;
  logic [1:0]  o_pop_cnt;
`ifdef FIFO_DRAIN_ACC_SATURATE_EN
  logic        o_sat;
`endif

  fifo_drain_accumulator #(
    .DATA_WIDTH (16),
    .PAR_READ   (1),
    .SUM_LEN    (2),
    .ACC_WIDTH  (16)
  ) u_ovf (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (o_start),
    .fifo_valid (o_valid),
    .fifo_data  (o_data),
    .fifo_r_en  (o_r_en),
    .sum_out    (o_sum_out),
    .sum_valid  (o_sum_valid),
    .sum_ready  (o_ready),
    .busy       (o_busy),
`ifdef FIFO_DRAIN_ACC_SATURATE_EN
    .sat_flag   (o_sat),
`endif
    .pop_cnt    (o_pop_cnt)
  );

  logic [31:0] m_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] grp(input int a, input int b);
    return {16'(b), 16'(a)};
  endfunction

  // Expected total of the queued groups: plain signed arithmetic, reduced mod 2^40.
  function automatic logic [39:0] main_model();
    longint s = 0;
    logic signed [15:0] l0, l1;
    foreach (m_q[k]) begin
      l0 = m_q[k][15:0];
      l1 = m_q[k][31:16];
      s += l0;
      s += l1;
    end
    return s[39:0];
  endfunction

  task automatic run_main(input int p_valid, input int hold, input bit poke);
    logic [39:0] exp;
    int pops = 0;
    int cyc  = 0;
    exp = main_model();
    @(negedge clk);
    m_start = 1'b1;
    m_valid = 1'b1;
    m_data  = $urandom;
    #1 check_eq("idle_r_en", m_r_en, 0);
    @(negedge clk);
    m_start = 1'b0;
    check_eq("accum_busy", m_busy, 1);
    while (pops < 3 && cyc < 200) begin
      cyc++;
      m_valid = ($urandom_range(99) < p_valid);
      m_data  = m_valid ? m_q[pops] : $urandom;
      if (poke) m_start = 1'($urandom_range(1));
      #1;
      check_eq("accum_r_en", m_r_en, m_valid);
      check_eq("accum_pop_cnt", m_pop_cnt, pops);
      @(negedge clk);
      if (m_valid) pops++;
      m_start = 1'b0;
    end
    check_eq("pop_budget", pops, 3);
    m_valid = 1'b1;
    m_data  = $urandom;
    for (int k = 0; k < hold; k++) begin
      if (poke) m_start = 1'($urandom_range(1));
      #1;
      check_eq("hold_valid", m_sum_valid, 1);
      check_eq("hold_sum", m_sum_out, exp);
      check_eq("hold_pop_cnt", m_pop_cnt, 3);
      check_eq("hold_r_en", m_r_en, 0);
      check_eq("hold_busy", m_busy, 1);
`ifdef FIFO_DRAIN_ACC_SATURATE_EN
      check_eq("hold_sat", m_sat, 0);
`endif
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    m_start = 1'b0;
    m_valid = 1'b0;
    check_eq("done_valid", m_sum_valid, 0);
    check_eq("done_busy", m_busy, 0);
  endtask

  task automatic run_ovf(input logic [15:0] a, input logic [15:0] b);
    longint s = 0;
    bit flag = 0;
    logic signed [15:0] w[2];
    logic [15:0] exp;
    w[0] = a;
    w[1] = b;
    for (int k = 0; k < 2; k++) begin
      s += w[k];
`ifdef FIFO_DRAIN_ACC_SATURATE_EN
      if (s > 32767)       begin s = 32767;  flag = 1; end
      else if (s < -32768) begin s = -32768; flag = 1; end
`endif
    end
    exp = s[15:0];
    @(negedge clk);
    o_start = 1'b1;
    @(negedge clk);
    o_start = 1'b0;
    o_valid = 1'b1;
    o_data  = a;
    @(negedge clk);
    o_data  = b;
    @(negedge clk);
    o_valid = 1'b0;
    check_eq("ovf_valid", o_sum_valid, 1);
    check_eq("ovf_sum", o_sum_out, exp);
    check_eq("ovf_pop_cnt", o_pop_cnt, 2);
`ifdef FIFO_DRAIN_ACC_SATURATE_EN
    check_eq("ovf_sat", o_sat, flag);
`else
    if (flag) check_eq("ovf_model", 1, 0);
`endif
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    check_eq("ovf_done", o_sum_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    m_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_r_en", m_r_en, 0);
    check_eq("rst_busy", m_busy, 0);
    check_eq("rst_valid", m_sum_valid, 0);
    check_eq("rst_sum", m_sum_out, 0);
    check_eq("rst_pop_cnt", m_pop_cnt, 0);
    check_eq("rst_ovf_valid", o_sum_valid, 0);
    m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    m_q = '{grp(5, 0), grp(-2, 0), grp(7, 0)};
    run_main(100, 1, 0);
    m_q = '{grp(3, 4), grp(-1, -6), grp(0, 0)};
    run_main(100, 5, 0);
    m_q = '{grp(1, 0), grp(2, 0), grp(3, 0)};
    run_main(50, 2, 1);

    // Reset after two pops must discard the partial sum.
    @(negedge clk);
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    m_valid = 1'b1;
    m_data  = grp(9, 9);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_r_en", m_r_en, 0);
    check_eq("midrst_busy", m_busy, 0);
    check_eq("midrst_pop_cnt", m_pop_cnt, 0);
    check_eq("midrst_valid", m_sum_valid, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    m_valid = 1'b0;
    m_q = '{grp(4, 0), grp(4, 0), grp(4, 0)};
    run_main(100, 1, 0);

    for (int r = 0; r < 20; r++) begin
      m_q.delete();
      for (int k = 0; k < 3; k++) m_q.push_back($urandom);
      run_main(int'($urandom_range(100, 30)), int'($urandom_range(4, 1)), 1);
    end

    run_ovf(16'h7FFF, 16'h0001);
    run_ovf(16'h8000, 16'hFFFF);
    run_ovf(16'h1234, 16'hFF00);
    for (int r = 0; r < 8; r++) run_ovf(16'($urandom), 16'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
